display_scan: RTL and testbench
===============================

Name: display_scan

Overview:
- Time-multiplexed digit scanner sitting directly upstream of the 7-segment decoder.
- Holds a multi-digit value of 4-bit nibbles and presents one nibble at a time on binary_code_o, which feeds the decoder's binary_code input.
- Drives the per-digit common anode enables in step with the nibble, and inserts a blanking gap between digits to suppress ghosting.
- Value updates are applied only at frame boundaries so a displayed number never tears.

Parameters:
- NUM_DIGITS, 4: number of multiplexed digits (>=2).
- REFRESH_DIV, 50000: clock cycles per digit slot (>=2).
- BLANK_CYCLES, 1000: cycles at the start of each slot with all anodes off. Range 0..REFRESH_DIV-1.
- ANODE_ACTIVE_LOW, 1: 1 means an anode is on when driven 0; 0 means on when driven 1.

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: reset.
- value_i, input, 4*NUM_DIGITS: nibble k (bits 4k+3:4k) is digit k; digit 0 is rightmost.
- load_i, input, 1: single-cycle strobe that captures value_i.
- digit_en_i, input, NUM_DIGITS: per-digit enable. A disabled digit's anode stays off.
- binary_code_o, output, 4: nibble of the current digit, to the segment decoder.
- anodes_o, output, NUM_DIGITS: digit enables, polarity per ANODE_ACTIVE_LOW.
- scan_tick_o, output, 1: one-cycle pulse on every digit advance.
- frame_o, output, 1: one-cycle pulse when the index wraps to digit 0.

Interface: one clock; reset is asynchronous and active-low (clk, rst_n). All outputs are registered.

Behaviour:
- Reset (async assert, sync release):
  - slot counter cnt=0, digit index idx=0.
  - active_q=0, pending_q=0, pend_flag=0.
  - binary_code_o=0, scan_tick_o=0, frame_o=0.
  - anodes_o all inactive: all-ones if ANODE_ACTIVE_LOW, else all-zeros.
  - Assertion mid-slot forces these values immediately, with no clock required.
- Slot counter:
  - cnt runs 0..REFRESH_DIV-1 and wraps to 0.
  - On the wrap, idx advances: idx+1, or 0 after NUM_DIGITS-1.
  - Width is $clog2(REFRESH_DIV); idx width is $clog2(NUM_DIGITS).
- Phase FSM per slot:
  - BLANK while cnt < BLANK_CYCLES: all anodes inactive.
  - SHOW while cnt >= BLANK_CYCLES: anodes_o bit idx active iff digit_en_i[idx], all other bits inactive.
  - With BLANK_CYCLES=0 there is no BLANK phase.
  - Outputs are computed from next-state values, so anodes_o matches cnt/idx in the same cycle.
  - digit_en_i is sampled every cycle, so a change shows on anodes_o the next cycle.
- binary_code_o:
  - Equals active_q nibble [idx], updated in the cycle idx changes.
  - Held for the whole slot, including BLANK, so the decoder settles before the anode turns on.
- scan_tick_o: 1 in the first cycle of every slot (cnt==0), except the first slot after reset.
- frame_o: 1 in the first cycle of a slot whose idx==0, same reset exception.
- Value update:
  - load_i=1 captures value_i into pending_q and sets pend_flag.
  - On a frame wrap (idx NUM_DIGITS-1 -> 0) with pend_flag=1: active_q<=pending_q, pend_flag<=0. The new digit 0 nibble comes from the new value.
  - load_i in the same cycle as the frame wrap: value_i goes directly into active_q and pend_flag stays 0.
  - Multiple loads within one frame: last one wins.
- No combinational path from any input to any output.

Test Plan (NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2, ANODE_ACTIVE_LOW=1):
1. Reset, then release with digit_en_i=4'hF:
   - binary_code_o=0 and anodes_o=4'b1111 during cnt 0-1.
   - anodes_o=4'b1110 during cnt 2-7.
   - At cnt=0 of the next slot: scan_tick_o=1 and anodes_o=4'b1111, then 4'b1101 from cnt 2.
   - Full frame is 32 cycles; frame_o pulses every 32 cycles.
2. load_i with value_i=16'h4321 at slot 1, cnt 3:
   - binary_code_o stays 0 for slots 1-3.
   - From the next frame, binary_code_o reads 1,2,3,4 on idx 0..3.
3. digit_en_i=4'b0101:
   - anodes_o active only in the SHOW phases of idx 0 and 2 (4'b1110, 4'b1011).
   - 4'b1111 throughout slots 1 and 3, while binary_code_o still cycles.
4. Two loads in one frame (16'hAAAA then 16'h5678):
   - Next frame shows 8,7,6,5.
   - A load coinciding with the wrap cycle is shown immediately on digit 0.
5. rst_n asserted at slot 2, cnt 5 (anode on):
   - anodes_o=4'b1111 and binary_code_o=0 without a clock edge.
   - After release, the scan restarts at idx 0 and active_q=0.
6. BLANK_CYCLES=0 variant: an anode is active on every cycle and changes exactly at each scan_tick_o.

Source files
------------

// File: rtl/display_scan.sv
// display_scan: time-multiplexed nibble scanner with per-slot anode blanking and frame-synchronous value updates
module display_scan #(
    parameter int NUM_DIGITS       = 4,
    parameter int REFRESH_DIV      = 50000,
    parameter int BLANK_CYCLES     = 1000,
    parameter bit ANODE_ACTIVE_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] value_i,
    input  logic                    load_i,
    input  logic [NUM_DIGITS-1:0]   digit_en_i,
    output logic [3:0]              binary_code_o,
    output logic [NUM_DIGITS-1:0]   anodes_o,
    output logic                    scan_tick_o,
    output logic                    frame_o
);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] ANODE_OFF = ANODE_ACTIVE_LOW ? '1 : '0;

    typedef enum logic {BLANK, SHOW} phase_e;

    logic [CW-1:0]           cnt_q, cnt_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] active_q, active_d, pending_q, pending_d;
    logic                    pend_q, pend_d;
    logic [3:0]              binary_q, binary_d;
    logic [NUM_DIGITS-1:0]   anodes_q, anodes_d;
    logic                    tick_q, tick_d, frame_q, frame_d;
    logic                    wrap, frame_wrap, in_show;
    phase_e                  phase_d;

    // With no blanking the comparison would be constant, so it is dropped entirely
    if (BLANK_CYCLES == 0) begin : g_noblank
        assign in_show = 1'b1;
    end else begin : g_blank
        assign in_show = cnt_d >= CW'(BLANK_CYCLES);
    end

    // Next-state: slot counter, digit index, frame-synchronous value swap, and outputs from next-state values
    always_comb begin
        wrap       = cnt_q == CNT_MAX;
        frame_wrap = wrap && idx_q == IDX_MAX;
        cnt_d      = wrap ? '0 : cnt_q + 1'b1;
        idx_d      = !wrap ? idx_q : (idx_q == IDX_MAX ? '0 : idx_q + 1'b1);
        active_d   = !frame_wrap ? active_q : load_i ? value_i : pend_q ? pending_q : active_q;
        pending_d  = load_i ? value_i : pending_q;
        pend_d     = !frame_wrap && (load_i || pend_q);
        phase_d    = in_show ? SHOW : BLANK;
        anodes_d   = ANODE_OFF ^ ((phase_d == SHOW) ? (digit_en_i & (NUM_DIGITS'(1) << idx_d)) : '0);
        binary_d   = active_d[{idx_d, 2'b00} +: 4];
        tick_d     = wrap;
        frame_d    = frame_wrap;
    end

    // State and registered outputs; reset forces blanked anodes immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            idx_q     <= '0;
            active_q  <= '0;
            pending_q <= '0;
            pend_q    <= 1'b0;
            binary_q  <= '0;
            anodes_q  <= ANODE_OFF;
            tick_q    <= 1'b0;
            frame_q   <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            pend_q    <= pend_d;
            binary_q  <= binary_d;
            anodes_q  <= anodes_d;
            tick_q    <= tick_d;
            frame_q   <= frame_d;
        end
    end

    assign binary_code_o = binary_q;
    assign anodes_o      = anodes_q;
    assign scan_tick_o   = tick_q;
    assign frame_o       = frame_q;
endmodule

// File: tb/tb_display_scan.sv
// tb_display_scan: randomized and directed check of display_scan against a cycle-count model
module tb_display_scan;
    localparam int N = 4;
    localparam int R = 8;
    localparam int F = N * R;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] value_i = '0;
    logic        load_i = 1'b0;
    logic [3:0]  digit_en_i = 4'hF;
    logic [3:0]  bin_a, an_a, bin_b, an_b;
    logic        tick_a, frm_a, tick_b, frm_b;

    int n_cmp = 0;
    int n_bad = 0;
    int t = 0;
    logic [15:0] last_val = '0;
    logic [15:0] frame_val = '0;
    logic [3:0]  en_prev = '0;

    always #5 clk = ~clk;

    display_scan #(.NUM_DIGITS(N), .REFRESH_DIV(R), .BLANK_CYCLES(2), .ANODE_ACTIVE_LOW(1)) u_a (
        .clk(clk), .rst_n(rst_n), .value_i(value_i), .load_i(load_i), .digit_en_i(digit_en_i),
        .binary_code_o(bin_a), .anodes_o(an_a), .scan_tick_o(tick_a), .frame_o(frm_a));

    display_scan #(.NUM_DIGITS(N), .REFRESH_DIV(R), .BLANK_CYCLES(0), .ANODE_ACTIVE_LOW(1)) u_b (
        .clk(clk), .rst_n(rst_n), .value_i(value_i), .load_i(load_i), .digit_en_i(digit_en_i),
        .binary_code_o(bin_b), .anodes_o(an_b), .scan_tick_o(tick_b), .frame_o(frm_b));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0d: got %h expected %h", nm, t, act, exp);
        end
    endtask

    function automatic logic [3:0] exp_an(input int blank);
        int cnt = t % R;
        int idx = (t / R) % N;
        return (t > 0 && cnt >= blank && en_prev[idx]) ? ~(4'b0001 << idx) : 4'hF;
    endfunction

    // Model: t edges since reset release; frame f shows the last value loaded in a cycle before f*F
    always @(posedge clk) begin
        logic ld;
        logic [15:0] v;
        logic [3:0] en;
        if (!rst_n) begin
            t = 0;
            last_val = '0;
            frame_val = '0;
            en_prev = '0;
        end else begin
            ld = load_i;
            v = value_i;
            en = digit_en_i;
            #1;
            t++;
            en_prev = en;
            if (ld) last_val = v;
            if (t % F == 0) frame_val = last_val;
            chk("bin_a", bin_a, (frame_val >> (4 * ((t / R) % N))) & 16'hF);
            chk("bin_b", bin_b, (frame_val >> (4 * ((t / R) % N))) & 16'hF);
            chk("an_a", an_a, exp_an(2));
            chk("an_b", an_b, exp_an(0));
            chk("tick_a", tick_a, (t % R) == 0);
            chk("tick_b", tick_b, (t % R) == 0);
            chk("frame_a", frm_a, (t % F) == 0);
            chk("frame_b", frm_b, (t % F) == 0);
        end
    end

    task automatic wait_t(input int target);
        int guard = 0;
        while (t != target && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (t != target) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_t: reached %0d required %0d", t, target);
        end
    endtask

    task automatic pulse(input logic [15:0] v);
        load_i = 1'b1;
        value_i = v;
        @(negedge clk);
        load_i = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("lit_reset_an", an_a, 4'hF);
        chk("lit_reset_bin", bin_a, 4'h0);
        wait_t(1);
        chk("lit_noblank_an", an_b, 4'b1110);
        wait_t(2);
        chk("lit_show0", an_a, 4'b1110);
        wait_t(8);
        chk("lit_tick", tick_a, 1'b1);
        chk("lit_blank1", an_a, 4'hF);
        chk("lit_noblank_slot1", an_b, 4'b1101);
        wait_t(10);
        chk("lit_show1", an_a, 4'b1101);
        wait_t(11);
        pulse(16'h4321);
        wait_t(16);
        chk("lit_no_tear", bin_a, 4'h0);
        wait_t(32);
        chk("lit_frame", frm_a, 1'b1);
        chk("lit_digit0", bin_a, 4'h1);
        wait_t(56);
        chk("lit_digit3", bin_a, 4'h4);
        wait_t(63);
        digit_en_i = 4'b0101;
        wait_t(66);
        chk("lit_en_d0", an_a, 4'b1110);
        wait_t(74);
        chk("lit_en_d1_off", an_a, 4'hF);
        chk("lit_en_d1_bin", bin_a, 4'h2);
        wait_t(82);
        chk("lit_en_d2", an_a, 4'b1011);
        wait_t(100);
        pulse(16'hAAAA);
        wait_t(110);
        pulse(16'h5678);
        wait_t(128);
        chk("lit_last_wins", bin_a, 4'h8);
        wait_t(136);
        chk("lit_last_wins1", bin_a, 4'h7);
        wait_t(159);
        pulse(16'h9ABC);
        chk("lit_wrap_load", bin_a, 4'hC);
        wait_t(181);
        chk("lit_pre_reset_an", an_a, 4'b1011);
        #2;
        rst_n = 1'b0;
        #1;
        chk("lit_async_an", an_a, 4'hF);
        chk("lit_async_bin", bin_a, 4'h0);
        chk("lit_async_an_b", an_b, 4'hF);
        repeat (2) @(negedge clk);
        digit_en_i = 4'hF;
        rst_n = 1'b1;
        wait_t(18);
        chk("lit_restart_idx2", an_a, 4'b1011);
        chk("lit_restart_bin", bin_a, 4'h0);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            load_i = $urandom_range(0, 9) == 0;
            value_i = 16'($urandom);
            if ($urandom_range(0, 15) == 0) digit_en_i = 4'($urandom);
            if (i % 1000 == 999) begin
                load_i = 1'b0;
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
        end
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
